// File: rtl/suma_serie_ctrl.sv
// Bit-serial adder controller: adds two N-bit operands LSB-first through one shared full-adder cell.
// Latency: N+1 cycles from accepting edge to done pulse; one addition per N+2 cycles.
// Backpressure: start is honoured only in IDLE; requests while busy or in FIN are dropped, not queued.

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (x & ci) | (y & ci);
endmodule

module suma_serie_ctrl #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         cout
);

  typedef enum logic [1:0] {IDLE, SUMA, FIN} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  ra, rb, acc;
  logic          c;
  logic [CW-1:0] cnt;
  logic          bit_s, carry, last;

  fa_cell u_fa (
    .x   (ra[0]),
    .y   (rb[0]),
    .ci  (c),
    .sum (bit_s),
    .co  (carry)
  );

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SUMA;
      SUMA:    if (last)  state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result registers load only on the final bit, so s/cout never show a partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra   <= '0;
      rb   <= '0;
      acc  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      s    <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            c   <= cin;
            acc <= '0;
            cnt <= '0;
          end
        end
        SUMA: begin
          acc <= {bit_s, acc[N-1:1]};
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          c   <= carry;
          cnt <= cnt + CW'(1);
          if (last) begin
            s    <= {bit_s, acc[N-1:1]};
            cout <= carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SUMA);
  assign done = (state == FIN);

endmodule

// File: tb/tb_suma_serie_ctrl.sv
// Bench for suma_serie_ctrl: N=4 and N=8 instances checked every cycle against a
// cycle-count/arithmetic model, plus hand-computed literal results.
module tb_suma_serie_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, s8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  suma_serie_ctrl #(.N(4), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4)
  );

  suma_serie_ctrl #(.N(8), .CW(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8)
  );

  task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // Model: ph=0 idle, 1..N busy cycles, N+1 done cycle; result is plain a+b+cin.
  int         ph[2];
  logic [8:0] pend[2];
  logic [8:0] res[2];

  always @(posedge clk or negedge rst_n) begin
    int nn;
    logic st;
    logic [8:0] sm;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        ph[i]  = 0;
        res[i] = '0;
      end else begin
        nn = (i == 0) ? 4 : 8;
        st = (i == 0) ? start4 : start8;
        sm = (i == 0) ? (9'(a4) + 9'(b4) + 9'(cin4)) : (9'(a8) + 9'(b8) + 9'(cin8));
        if (ph[i] == 0) begin
          if (st) begin
            pend[i] = sm;
            ph[i]   = 1;
          end
        end else if (ph[i] < nn) begin
          ph[i] = ph[i] + 1;
        end else if (ph[i] == nn) begin
          res[i] = pend[i];
          ph[i]  = nn + 1;
        end else begin
          ph[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("d4_busy", 9'(busy4), 9'(ph[0] >= 1 && ph[0] <= 4));
    check("d4_done", 9'(done4), 9'(ph[0] == 5));
    check("d4_s",    9'(s4),    9'(res[0][3:0]));
    check("d4_cout", 9'(cout4), 9'(res[0][4]));
    check("d8_busy", 9'(busy8), 9'(ph[1] >= 1 && ph[1] <= 8));
    check("d8_done", 9'(done8), 9'(ph[1] == 9));
    check("d8_s",    9'(s8),    9'(res[1][7:0]));
    check("d8_cout", 9'(cout8), 9'(res[1][8]));
  end

  task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
  endtask

  task automatic wait_done4(input string nm);
    int n = 0;
    while (!done4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done4) check({nm, "_timeout"}, 9'd0, 9'd1);
  endtask

  task automatic expect4(input string nm, input logic [3:0] es, input logic ec);
    check({nm, "_s"},    9'(s4),    9'(es));
    check({nm, "_cout"}, 9'(cout4), 9'(ec));
  endtask

  initial begin
    int nb;
    int seen;
    // 1: reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t1_busy", 9'(busy4), 9'd0);
    check("t1_done", 9'(done4), 9'd0);
    expect4("t1", 4'h0, 1'b0);

    // 2: 0101 + 0011
    go4(4'h5, 4'h3, 1'b0);
    check("t2_busy_e0", 9'(busy4), 9'd1);
    repeat (3) @(negedge clk);
    expect4("t2_hold", 4'h0, 1'b0);
    wait_done4("t2");
    expect4("t2", 4'h8, 1'b0);

    // 3: boundary operands
    go4(4'hF, 4'h1, 1'b0); wait_done4("t3a"); expect4("t3a", 4'h0, 1'b1);
    go4(4'h0, 4'h0, 1'b1); wait_done4("t3b"); expect4("t3b", 4'h1, 1'b0);
    go4(4'hF, 4'hF, 1'b1); wait_done4("t3c"); expect4("t3c", 4'hF, 1'b1);

    // 4: start during SUMA and FIN ignored, accepted at EN+2
    go4(4'h5, 4'h3, 1'b0);
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done4("t4a");
    expect4("t4a", 4'h8, 1'b0);
    a4 = 4'h2; b4 = 4'h3; cin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    check("t4_fin_ignored", 9'(busy4), 9'd0);
    @(negedge clk);
    start4 = 1'b0;
    check("t4_accept", 9'(busy4), 9'd1);
    wait_done4("t4b");
    expect4("t4b", 4'h5, 1'b0);

    // 5: asynchronous reset mid-operation
    go4(4'h1, 4'h2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", 9'(busy4), 9'd0);
    expect4("t5_rst", 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4) seen = 1;
    end
    check("t5_no_done", 9'(seen), 9'd0);
    go4(4'h5, 4'h3, 1'b0);
    wait_done4("t5");
    expect4("t5", 4'h8, 1'b0);

    // 6: N=8 instance, 0xC8 + 0x64 + 1
    @(negedge clk);
    a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    nb = 0;
    while (busy8 && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    check("t6_busy_cycles", 9'(nb), 9'd8);
    check("t6_done", 9'(done8), 9'd1);
    check("t6_s", 9'(s8), 9'h2D);
    check("t6_cout", 9'(cout8), 9'd1);
    @(negedge clk);
    check("t6_done_pulse", 9'(done8), 9'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/suma_serie_ctrl.md
Name: suma_serie_ctrl

Overview:
Bit-serial adder controller. It adds two N-bit operands by sequencing them LSB-first through one shared 1-bit full-adder cell, one bit per clock. It trades area for latency.
- Sits between a register/bus front end and the shared adder cell.
- Owns operand shifting, carry storage, bit counting, result assembly and the start/busy/done handshake.

Parameters:
N, 4, operand and result width in bits (legal range 2..16).
CW, 4, bit-counter width; must satisfy 2^CW > N.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request to begin an addition; sampled only in IDLE.
a  input  N  operand A; captured on the accepting edge.
b  input  N  operand B; captured on the accepting edge.
cin  input  1  carry-in; captured on the accepting edge.
busy  output  1  high while bits are being processed (state SUMA).
done  output  1  one-cycle pulse; s/cout valid and final.
s  output  N  sum register; holds the last completed result.
cout  output  1  carry-out register; holds the last completed result.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; busy=0; done=0; s=0; cout=0.
  - Internal shift registers, carry flop and counter cleared.
  - An in-flight operation is abandoned; no partial result reaches s.
- States: IDLE, SUMA, FIN. The state is registered. busy=(state==SUMA) and done=(state==FIN) are decoded from the state, glitch-free.
- IDLE:
  - start=1 at edge E0: ra<=a, rb<=b, c<=cin, acc<=0, cnt<=0, next state SUMA.
  - start=0: remain in IDLE.
  - a, b and cin are ignored except at the accepting edge.
- SUMA, each edge Ek (k=1..N):
  - Adder cell computes bit=ra[0]^rb[0]^c and carry=maj(ra[0],rb[0],c).
  - acc<={bit, acc[N-1:1]}; ra, rb shift right (zero fill); c<=carry; cnt<=cnt+1.
  - When cnt==N-1 at the edge: s<={bit, acc[N-1:1]}, cout<=carry, next state FIN.
- FIN: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: start accepted at E0; busy high for N cycles (E0..EN); done high between EN and EN+1. A new start is accepted at earliest at edge EN+2, giving a throughput of one addition per N+2 cycles.
- start while busy or in FIN is ignored and is not queued. Operand changes during SUMA have no effect.
- s/cout change only at the completion edge. During an operation they hold the previous result, so they are never partially updated.
- Arithmetic: {cout,s} = a + b + cin, modulo 2^(N+1). Overflow is expressed only through cout.
- Exactly one full-adder cell is instantiated. No N-bit parallel adder is permitted.
- cnt never exceeds N-1. There is no wrap-around path in SUMA.

Test Plan:
1. Reset, N=4 → busy=0, done=0, s=0000, cout=0; start held low for 5 cycles → no change.
2. a=0101, b=0011, cin=0, start pulsed at E0 → busy high E0..E4; done pulse after E4; s=1000, cout=0; s stays 0000 until E4.
3. a=1111, b=0001, cin=0 → s=0000, cout=1. Then a=0000, b=0000, cin=1 → s=0001, cout=0. Then a=1111, b=1111, cin=1 → s=1111, cout=1.
4. start re-asserted with different operands at E2 and in FIN → ignored, result of the first operation unchanged. start at EN+2 → accepted, busy rises.
5. rst_n pulled low asynchronously mid-SUMA (between E2 and E3) → immediate IDLE, busy=0, s=0, cout=0, no done pulse. After release, a fresh 0101+0011 completes correctly with s=1000.
6. N=8, CW=4: a=0xC8, b=0x64, cin=1 → busy for 8 cycles; s=0x2D, cout=1; done exactly one cycle.
